pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_if.sv | 29 ++
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline sequencer and the datapath: hazard inputs,
// cache waits, CP0 redirect request, and the per-register stall/flush enables.
interface pipe_ctrl_if;
    logic        id_ld_use_i;
    logic        exe_div_i;
    logic        icache_stall_i;
    logic        dcache_stall_i;
    logic        exc_valid_i;
    logic [31:0] exc_pc_i;
    logic        pc_ack_i;
    logic [4:0]  stall_o;
    logic [4:0]  flush_o;
    logic        redir_valid_o;
    logic [31:0] redir_pc_o;
    logic        div_start_o;
    logic        div_ready_o;

    modport master (
        input  id_ld_use_i, exe_div_i, icache_stall_i, dcache_stall_i,
        input  exc_valid_i, exc_pc_i, pc_ack_i,
        output stall_o, flush_o, redir_valid_o, redir_pc_o, div_start_o, div_ready_o
    );

    modport slave (
        output id_ld_use_i, exe_div_i, icache_stall_i, dcache_stall_i,
        output exc_valid_i, exc_pc_i, pc_ack_i,
        input  stall_o, flush_o, redir_valid_o, redir_pc_o, div_start_o, div_ready_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline: load-use bubbles,
// multi-cycle divide, cache waits and exception/ERET redirects.
module pipe_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.master  bus
);

    typedef enum logic [1:0] {RUN, DIV_BUSY, DIV_DONE, REDIR_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0]      redir_pc, redir_pc_n;
    logic             redir_valid, redir_valid_n;
    logic             div_start, div_start_n;
    logic [4:0]       stall, flush;
    logic             div_ready;
    logic             fetch_free;

    // Redirect completes only once the PC unit has taken it and fetch is idle.
    assign fetch_free = bus.pc_ack_i && !bus.icache_stall_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            cnt         <= '0;
            redir_pc    <= '0;
            redir_valid <= 1'b0;
            div_start   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            redir_pc    <= redir_pc_n;
            redir_valid <= redir_valid_n;
            div_start   <= div_start_n;
        end
    end

    always_comb begin
        stall     = 5'b00000;
        flush     = 5'b00000;
        div_ready = 1'b0;
        if (rst) begin
            flush = 5'b11111;
        end else begin
            div_ready = (state == DIV_BUSY) && (cnt == CNT_LAST) &&
                        !bus.dcache_stall_i && !bus.exc_valid_i;
            if (bus.exc_valid_i) begin
                flush = 5'b11110;
            end else if (state == REDIR_WAIT) begin
                // Drop whatever wrong-path fetch data lands in IF/ID while waiting.
                flush = 5'b00010;
            end else if (bus.dcache_stall_i) begin
                stall = 5'b11111;
            end else if (state == DIV_BUSY) begin
                stall = 5'b00111;
                flush = 5'b01000;
            end else if (bus.icache_stall_i || bus.id_ld_use_i) begin
                stall = 5'b00011;
                flush = 5'b00100;
            end
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        redir_pc_n    = redir_pc;
        redir_valid_n = redir_valid;
        div_start_n   = 1'b0;
        if (bus.exc_valid_i) begin
            // An exception also aborts any divide in flight.
            redir_pc_n    = bus.exc_pc_i;
            redir_valid_n = 1'b1;
            cnt_n         = '0;
            state_n       = ((state == REDIR_WAIT) || !fetch_free) ? REDIR_WAIT : RUN;
        end else begin
            case (state)
                RUN: begin
                    redir_valid_n = 1'b0;
                    if (bus.exe_div_i && !bus.dcache_stall_i) begin
                        state_n     = DIV_BUSY;
                        cnt_n       = '0;
                        div_start_n = 1'b1;
                    end
                end
                DIV_BUSY: begin
                    redir_valid_n = 1'b0;
                    if (!bus.dcache_stall_i) begin
                        if (cnt == CNT_LAST) begin
                            state_n = DIV_DONE;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                end
                DIV_DONE: begin
                    redir_valid_n = 1'b0;
                    state_n       = RUN;
                end
                REDIR_WAIT: begin
                    if (fetch_free) begin
                        state_n       = RUN;
                        redir_valid_n = 1'b0;
                    end
                end
                default: begin
                    state_n = RUN;
                end
            endcase
        end
    end

    assign bus.stall_o       = stall;
    assign bus.flush_o       = flush;
    assign bus.div_ready_o   = div_ready;
    assign bus.redir_valid_o = redir_valid;
    assign bus.redir_pc_o    = redir_pc;
    assign bus.div_start_o   = div_start;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, hand-written divide/exception
// sequences, then random traffic against a cycle-count reference model.
module tb_pipe_ctrl;

    localparam int DIV_CYCLES = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic        lu, ic, dc, exc, ack;
        logic [31:0] pc;
        logic [4:0]  stall, flush;
        logic        rv;
    } vec_t;

    vec_t tbl[10];

    // Reference model: remaining divide cycles and pending-redirect flags.
    int          m_left;
    bit          m_done, m_wait, m_valid, m_start;
    logic [31:0] m_pc;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic apply_stimulus(input logic lu, input logic dv, input logic ic, input logic dc,
                                  input logic exc, input logic ack, input logic [31:0] pc);
        bus.id_ld_use_i    = lu;
        bus.exe_div_i      = dv;
        bus.icache_stall_i = ic;
        bus.dcache_stall_i = dc;
        bus.exc_valid_i    = exc;
        bus.pc_ack_i       = ack;
        bus.exc_pc_i       = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit verify);
        rst = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        if (verify) begin
            check_output("rst_flush", 32'(bus.flush_o), 32'h1F);
            check_output("rst_stall", 32'(bus.stall_o), 32'h0);
            check_output("rst_redir_valid", 32'(bus.redir_valid_o), 32'h0);
            check_output("rst_div_ready", 32'(bus.div_ready_o), 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        if (verify) begin
            check_output("post_rst_flush", 32'(bus.flush_o), 32'h0);
            check_output("post_rst_stall", 32'(bus.stall_o), 32'h0);
        end
        tick();
    endtask

    task automatic model_reset();
        m_left  = 0;
        m_done  = 0;
        m_wait  = 0;
        m_valid = 0;
        m_start = 0;
        m_pc    = '0;
    endtask

    task automatic model_expect(output logic [4:0] s, output logic [4:0] f, output logic r);
        s = 5'b00000;
        f = 5'b00000;
        r = (m_left == 1) && !bus.dcache_stall_i && !bus.exc_valid_i;
        if (bus.exc_valid_i)                          f = 5'b11110;
        else if (m_wait)                              f = 5'b00010;
        else if (bus.dcache_stall_i)                  s = 5'b11111;
        else if (m_left > 0) begin                    s = 5'b00111; f = 5'b01000; end
        else if (bus.icache_stall_i || bus.id_ld_use_i) begin s = 5'b00011; f = 5'b00100; end
    endtask

    task automatic model_advance();
        bit free;
        free    = bus.pc_ack_i && !bus.icache_stall_i;
        m_start = 0;
        if (bus.exc_valid_i) begin
            m_pc    = bus.exc_pc_i;
            m_valid = 1;
            m_left  = 0;
            m_done  = 0;
            m_wait  = m_wait || !free;
        end else if (m_wait) begin
            if (free) begin
                m_wait  = 0;
                m_valid = 0;
            end
        end else if (m_left > 0) begin
            m_valid = 0;
            if (!bus.dcache_stall_i) begin
                m_left--;
                if (m_left == 0) m_done = 1;
            end
        end else if (m_done) begin
            m_valid = 0;
            m_done  = 0;
        end else begin
            m_valid = 0;
            if (bus.exe_div_i && !bus.dcache_stall_i) begin
                m_left  = DIV_CYCLES;
                m_start = 1;
            end
        end
    endtask

    initial begin
        logic [4:0] es, ef;
        logic       er;

        tbl[0] = '{lu:0, ic:0, dc:0, exc:0, ack:0, pc:32'h0,        stall:5'b00000, flush:5'b00000, rv:0};
        tbl[1] = '{lu:1, ic:0, dc:0, exc:0, ack:0, pc:32'h0,        stall:5'b00011, flush:5'b00100, rv:0};
        tbl[2] = '{lu:0, ic:0, dc:0, exc:0, ack:0, pc:32'h0,        stall:5'b00000, flush:5'b00000, rv:0};
        tbl[3] = '{lu:0, ic:1, dc:0, exc:0, ack:0, pc:32'h0,        stall:5'b00011, flush:5'b00100, rv:0};
        tbl[4] = '{lu:0, ic:0, dc:1, exc:0, ack:0, pc:32'h0,        stall:5'b11111, flush:5'b00000, rv:0};
        tbl[5] = '{lu:1, ic:0, dc:1, exc:0, ack:0, pc:32'h0,        stall:5'b11111, flush:5'b00000, rv:0};
        tbl[6] = '{lu:1, ic:1, dc:0, exc:0, ack:0, pc:32'h0,        stall:5'b00011, flush:5'b00100, rv:0};
        tbl[7] = '{lu:0, ic:0, dc:1, exc:1, ack:1, pc:32'h80000180, stall:5'b00000, flush:5'b11110, rv:0};
        tbl[8] = '{lu:0, ic:0, dc:0, exc:0, ack:0, pc:32'h0,        stall:5'b00000, flush:5'b00000, rv:1};
        tbl[9] = '{lu:0, ic:0, dc:0, exc:0, ack:0, pc:32'h0,        stall:5'b00000, flush:5'b00000, rv:0};

        do_reset(1);

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(tbl[i].lu, 0, tbl[i].ic, tbl[i].dc, tbl[i].exc, tbl[i].ack, tbl[i].pc);
            @(negedge clk);
            check_output($sformatf("vec%0d_stall", i), 32'(bus.stall_o), 32'(tbl[i].stall));
            check_output($sformatf("vec%0d_flush", i), 32'(bus.flush_o), 32'(tbl[i].flush));
            check_output($sformatf("vec%0d_redir_valid", i), 32'(bus.redir_valid_o), 32'(tbl[i].rv));
            tick();
        end
        check_output("exc_dcache_redir_pc", bus.redir_pc_o, 32'h80000180);

        // Plain divide with exe_div held through the whole sequence.
        apply_stimulus(0, 1, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        check_output("div_entry_stall", 32'(bus.stall_o), 32'h0);
        tick();
        for (int i = 0; i < DIV_CYCLES; i++) begin
            @(negedge clk);
            check_output($sformatf("div%0d_stall", i), 32'(bus.stall_o), 32'h07);
            check_output($sformatf("div%0d_flush", i), 32'(bus.flush_o), 32'h08);
            check_output($sformatf("div%0d_start", i), 32'(bus.div_start_o), 32'(i == 0));
            check_output($sformatf("div%0d_ready", i), 32'(bus.div_ready_o), 32'(i == DIV_CYCLES - 1));
            tick();
        end
        @(negedge clk);
        check_output("div_done_stall", 32'(bus.stall_o), 32'h0);
        check_output("div_done_ready", 32'(bus.div_ready_o), 32'h0);
        check_output("div_done_start", 32'(bus.div_start_o), 32'h0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_output($sformatf("div_after%0d_start", i), 32'(bus.div_start_o), 32'h0);
            check_output($sformatf("div_after%0d_stall", i), 32'(bus.stall_o), 32'h0);
            tick();
        end

        // Divide with a 3-cycle dcache stall in the middle.
        apply_stimulus(0, 1, 0, 0, 0, 0, 32'h0);
        tick();
        for (int i = 0; i < DIV_CYCLES + 3; i++) begin
            logic dc;
            dc = (i >= 10 && i <= 12);
            apply_stimulus(0, 1, 0, dc, 0, 0, 32'h0);
            @(negedge clk);
            check_output($sformatf("divdc%0d_stall", i), 32'(bus.stall_o), dc ? 32'h1F : 32'h07);
            check_output($sformatf("divdc%0d_flush", i), 32'(bus.flush_o), dc ? 32'h00 : 32'h08);
            check_output($sformatf("divdc%0d_ready", i), 32'(bus.div_ready_o), 32'(i == DIV_CYCLES + 2));
            tick();
        end
        @(negedge clk);
        check_output("divdc_done_stall", 32'(bus.stall_o), 32'h0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0);
        tick();

        // Exception during a divide while fetch is missing.
        apply_stimulus(0, 1, 0, 0, 0, 0, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) tick();
        apply_stimulus(0, 1, 1, 0, 1, 0, 32'hBFC00380);
        @(negedge clk);
        check_output("exc_div_flush", 32'(bus.flush_o), 32'h1E);
        check_output("exc_div_stall", 32'(bus.stall_o), 32'h0);
        check_output("exc_div_ready", 32'(bus.div_ready_o), 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 0, 1, 0, 0, 0, 32'h0);
            @(negedge clk);
            check_output($sformatf("wait%0d_flush", i), 32'(bus.flush_o), 32'h02);
            check_output($sformatf("wait%0d_stall", i), 32'(bus.stall_o), 32'h0);
            check_output($sformatf("wait%0d_valid", i), 32'(bus.redir_valid_o), 32'h1);
            check_output($sformatf("wait%0d_pc", i), bus.redir_pc_o, 32'hBFC00380);
            check_output($sformatf("wait%0d_ready", i), 32'(bus.div_ready_o), 32'h0);
            tick();
        end
        apply_stimulus(0, 0, 0, 0, 0, 1, 32'h0);
        @(negedge clk);
        check_output("wait_ack_valid", 32'(bus.redir_valid_o), 32'h1);
        check_output("wait_ack_flush", 32'(bus.flush_o), 32'h02);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        check_output("wait_exit_valid", 32'(bus.redir_valid_o), 32'h0);
        check_output("wait_exit_flush", 32'(bus.flush_o), 32'h0);
        check_output("wait_exit_ready", 32'(bus.div_ready_o), 32'h0);
        tick();

        // Random traffic against the reference model.
        do_reset(0);
        model_reset();
        for (int i = 0; i < 2000; i++) begin
            apply_stimulus($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                           $urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0, $urandom);
            @(negedge clk);
            model_expect(es, ef, er);
            check_output($sformatf("rnd%0d_stall", i), 32'(bus.stall_o), 32'(es));
            check_output($sformatf("rnd%0d_flush", i), 32'(bus.flush_o), 32'(ef));
            check_output($sformatf("rnd%0d_ready", i), 32'(bus.div_ready_o), 32'(er));
            check_output($sformatf("rnd%0d_valid", i), 32'(bus.redir_valid_o), 32'(m_valid));
            check_output($sformatf("rnd%0d_pc", i), bus.redir_pc_o, m_pc);
            check_output($sformatf("rnd%0d_start", i), 32'(bus.div_start_o), 32'(m_start));
            model_advance();
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
